vec_reg_ctrl: RTL and testbench

Controller for the vector register file, which has one write port and two read ports with 128-bit data and 5-bit addresses.
- Keeps a per-register busy scoreboard and stalls vector issue on RAW and WAW hazards.
- Arbitrates the single write port between two writeback sources, the vector ALU and the vector load unit, using round-robin.
- Drives the register file write enable, destination and data from registered outputs.
- Sits in Decode, between the issue logic and the vector register file.

---
 rtl/vec_reg_ctrl.sv | 125 ++++++++++++
 tb/tb_vec_reg_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_reg_ctrl.sv
// Vector register file controller: busy scoreboard with RAW/WAW issue stall,
// round-robin writeback arbitration (ALU vs. load unit) and registered write port.
module vec_reg_ctrl #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int DW    = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   input  logic [AW-1:0]    issue_rs1,
   input  logic [AW-1:0]    issue_rs2,
   input  logic [AW-1:0]    issue_rd,
   input  logic             issue_wr,
   output logic             issue_stall,
   input  logic             alu_wb_valid,
   input  logic [AW-1:0]    alu_wb_rd,
   input  logic [DW-1:0]    alu_wb_data,
   output logic             alu_wb_ready,
   input  logic             mem_wb_valid,
   input  logic [AW-1:0]    mem_wb_rd,
   input  logic [DW-1:0]    mem_wb_data,
   output logic             mem_wb_ready,
   output logic             rf_we,
   output logic [AW-1:0]    rf_rd,
   output logic [DW-1:0]    rf_wdata,
   output logic [NREGS-1:0] busy,
   output logic             wb_err
);

   logic             prio_mem_r;
   logic [NREGS-1:0] busy_r;
   logic [NREGS-1:0] busy_nxt_s;
   logic             rf_we_r;
   logic [AW-1:0]    rf_rd_r;
   logic [DW-1:0]    rf_wdata_r;
   logic             wb_err_r;
   logic             stall_s;
   logic             accept_s;
   logic             alu_gnt_s;
   logic             mem_gnt_s;
   logic             xfer_s;
   logic [AW-1:0]    wb_rd_s;
   logic [DW-1:0]    wb_data_s;

   // Hazard check and issue acceptance
   always_comb begin
      stall_s  = issue_valid & (busy_r[issue_rs1] | busy_r[issue_rs2] |
                                (issue_wr & busy_r[issue_rd]));
      accept_s = issue_valid & ~stall_s;
   end

   // Round-robin grant; prio_mem_r set means the load unit wins a tie
   always_comb begin
      alu_gnt_s = 1'b0;
      mem_gnt_s = 1'b0;
      if (alu_wb_valid && mem_wb_valid) begin
         alu_gnt_s = ~prio_mem_r;
         mem_gnt_s = prio_mem_r;
      end else begin
         alu_gnt_s = alu_wb_valid;
         mem_gnt_s = mem_wb_valid;
      end
      xfer_s = alu_gnt_s | mem_gnt_s;
   end

   // Writeback source select
   always_comb begin
      wb_rd_s   = {AW{1'b0}};
      wb_data_s = {DW{1'b0}};
      if (mem_gnt_s) begin
         wb_rd_s   = mem_wb_rd;
         wb_data_s = mem_wb_data;
      end else begin
         wb_rd_s   = alu_wb_rd;
         wb_data_s = alu_wb_data;
      end
   end

   // Scoreboard update: clear on the write edge, then set on accepted issue
   always_comb begin
      busy_nxt_s = busy_r;
      if (rf_we_r) begin
         busy_nxt_s[rf_rd_r] = 1'b0;
      end else begin
         busy_nxt_s[rf_rd_r] = busy_r[rf_rd_r];
      end
      if (accept_s && issue_wr) begin
         busy_nxt_s[issue_rd] = 1'b1;
      end else begin
         busy_nxt_s[issue_rd] = busy_nxt_s[issue_rd];
      end
   end

   // State registers: scoreboard, arbitration pointer, write port outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r     <= {NREGS{1'b0}};
         prio_mem_r <= 1'b0;
         rf_we_r    <= 1'b0;
         rf_rd_r    <= {AW{1'b0}};
         rf_wdata_r <= {DW{1'b0}};
         wb_err_r   <= 1'b0;
      end else begin
         busy_r   <= busy_nxt_s;
         rf_we_r  <= xfer_s;
         wb_err_r <= xfer_s & ~busy_r[wb_rd_s];
         if (xfer_s) begin
            prio_mem_r <= alu_gnt_s;
            rf_rd_r    <= wb_rd_s;
            rf_wdata_r <= wb_data_s;
         end
      end
   end

   assign issue_stall  = stall_s;
   assign alu_wb_ready = alu_gnt_s;
   assign mem_wb_ready = mem_gnt_s;
   assign rf_we        = rf_we_r;
   assign rf_rd        = rf_rd_r;
   assign rf_wdata     = rf_wdata_r;
   assign busy         = busy_r;
   assign wb_err       = wb_err_r;

endmodule

// File: tb/tb_vec_reg_ctrl.sv
// Directed self-checking bench for vec_reg_ctrl: reset, issue hazards,
// writeback arbitration, spurious writeback and reset during a transfer.
module tb_vec_reg_ctrl;

   logic           clk = 1'b0;
   logic           rst;
   logic           issue_valid;
   logic [4:0]     issue_rs1, issue_rs2, issue_rd;
   logic           issue_wr;
   logic           issue_stall;
   logic           alu_wb_valid;
   logic [4:0]     alu_wb_rd;
   logic [127:0]   alu_wb_data;
   logic           alu_wb_ready;
   logic           mem_wb_valid;
   logic [4:0]     mem_wb_rd;
   logic [127:0]   mem_wb_data;
   logic           mem_wb_ready;
   logic           rf_we;
   logic [4:0]     rf_rd;
   logic [127:0]   rf_wdata;
   logic [31:0]    busy;
   logic           wb_err;

   int pass_cnt = 0;
   int total_cnt = 0;

   localparam logic [127:0] DA5 = {16{8'hA5}};
   localparam logic [127:0] D1  = {4{32'h1111_0001}};
   localparam logic [127:0] D2  = {4{32'h2222_0002}};
   localparam logic [127:0] D3  = {4{32'h3333_0003}};
   localparam logic [127:0] D9  = {4{32'h9999_0009}};

   vec_reg_ctrl dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_stall(issue_stall),
      .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
      .alu_wb_ready(alu_wb_ready),
      .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
      .mem_wb_ready(mem_wb_ready),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_issue(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic wr);
      issue_valid = v; issue_rs1 = r1; issue_rs2 = r2; issue_rd = rd; issue_wr = wr;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; alu_wb_data = 128'd0;
      mem_wb_valid = 1'b0; mem_wb_rd = 5'd0; mem_wb_data = 128'd0;
      tick(); tick();
      rst = 1'b0;
      #1;
      total_cnt++; if (busy !== 32'h0) $display("FAIL rst_busy got %h want %h", busy, 32'h0); else pass_cnt++;
      total_cnt++; if (rf_we !== 1'b0) $display("FAIL rst_we got %b want 0", rf_we); else pass_cnt++;
      total_cnt++; if (wb_err !== 1'b0) $display("FAIL rst_err got %b want 0", wb_err); else pass_cnt++;
      total_cnt++; if (rf_rd !== 5'd0) $display("FAIL rst_rd got %0d want 0", rf_rd); else pass_cnt++;
      total_cnt++; if (rf_wdata !== 128'd0) $display("FAIL rst_wdata got %h want 0", rf_wdata); else pass_cnt++;
   endtask

   task automatic test_issue();
      set_issue(1'b1, 5'd3, 5'd4, 5'd5, 1'b1);
      #1;
      total_cnt++; if (issue_stall !== 1'b0) $display("FAIL iss_stall got %b want 0", issue_stall); else pass_cnt++;
      tick();
      issue_valid = 1'b0;
      total_cnt++; if (busy !== 32'h0000_0020) $display("FAIL iss_busy got %h want %h", busy, 32'h0000_0020); else pass_cnt++;
   endtask

   task automatic test_raw();
      set_issue(1'b1, 5'd5, 5'd0, 5'd6, 1'b0);
      #1;
      total_cnt++; if (issue_stall !== 1'b1) $display("FAIL raw_stall0 got %b want 1", issue_stall); else pass_cnt++;
      tick();
      alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = DA5;
      #1;
      total_cnt++; if (issue_stall !== 1'b1) $display("FAIL raw_stall1 got %b want 1", issue_stall); else pass_cnt++;
      total_cnt++; if (alu_wb_ready !== 1'b1) $display("FAIL raw_alu_rdy got %b want 1", alu_wb_ready); else pass_cnt++;
      total_cnt++; if (mem_wb_ready !== 1'b0) $display("FAIL raw_mem_rdy got %b want 0", mem_wb_ready); else pass_cnt++;
      tick();
      alu_wb_valid = 1'b0;
      #1;
      total_cnt++; if (rf_we !== 1'b1) $display("FAIL raw_we got %b want 1", rf_we); else pass_cnt++;
      total_cnt++; if (rf_rd !== 5'd5) $display("FAIL raw_rd got %0d want 5", rf_rd); else pass_cnt++;
      total_cnt++; if (rf_wdata !== DA5) $display("FAIL raw_wdata got %h want %h", rf_wdata, DA5); else pass_cnt++;
      total_cnt++; if (wb_err !== 1'b0) $display("FAIL raw_err got %b want 0", wb_err); else pass_cnt++;
      total_cnt++; if (issue_stall !== 1'b1) $display("FAIL raw_stall2 got %b want 1", issue_stall); else pass_cnt++;
      tick();
      total_cnt++; if (busy !== 32'h0) $display("FAIL raw_busy got %h want 0", busy); else pass_cnt++;
      total_cnt++; if (issue_stall !== 1'b0) $display("FAIL raw_stall3 got %b want 0", issue_stall); else pass_cnt++;
      total_cnt++; if (rf_we !== 1'b0) $display("FAIL raw_we_off got %b want 0", rf_we); else pass_cnt++;
      issue_valid = 1'b0;
   endtask

   task automatic test_waw();
      set_issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
      #1;
      total_cnt++; if (issue_stall !== 1'b0) $display("FAIL waw_set_stall got %b want 0", issue_stall); else pass_cnt++;
      tick();
      issue_valid = 1'b0;
      total_cnt++; if (busy !== 32'h0000_0080) $display("FAIL waw_busy got %h want %h", busy, 32'h0000_0080); else pass_cnt++;
      set_issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
      #1;
      total_cnt++; if (issue_stall !== 1'b1) $display("FAIL waw_stall got %b want 1", issue_stall); else pass_cnt++;
      issue_wr = 1'b0;
      #1;
      total_cnt++; if (issue_stall !== 1'b0) $display("FAIL waw_nowr_stall got %b want 0", issue_stall); else pass_cnt++;
      issue_valid = 1'b0;
      alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = D1;
      tick();
      alu_wb_valid = 1'b0;
      tick();
      total_cnt++; if (busy !== 32'h0) $display("FAIL waw_clr got %h want 0", busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_issue(1'b1, 5'd0, 5'd0, 5'd1, 1'b1);
      tick();
      issue_rd = 5'd2;
      tick();
      issue_valid = 1'b0;
      total_cnt++; if (busy !== 32'h0000_0006) $display("FAIL b2b_busy0 got %h want %h", busy, 32'h0000_0006); else pass_cnt++;
      alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = D1;
      mem_wb_valid = 1'b1; mem_wb_rd = 5'd2; mem_wb_data = D2;
      #1;
      total_cnt++; if (alu_wb_ready !== 1'b1) $display("FAIL b2b_alu_rdy1 got %b want 1", alu_wb_ready); else pass_cnt++;
      total_cnt++; if (mem_wb_ready !== 1'b0) $display("FAIL b2b_mem_rdy1 got %b want 0", mem_wb_ready); else pass_cnt++;
      tick();
      alu_wb_data = D3;
      #1;
      total_cnt++; if (mem_wb_ready !== 1'b1) $display("FAIL b2b_mem_rdy2 got %b want 1", mem_wb_ready); else pass_cnt++;
      total_cnt++; if (alu_wb_ready !== 1'b0) $display("FAIL b2b_alu_rdy2 got %b want 0", alu_wb_ready); else pass_cnt++;
      total_cnt++; if (rf_we !== 1'b1) $display("FAIL b2b_we1 got %b want 1", rf_we); else pass_cnt++;
      total_cnt++; if (rf_rd !== 5'd1) $display("FAIL b2b_rd1 got %0d want 1", rf_rd); else pass_cnt++;
      total_cnt++; if (rf_wdata !== D1) $display("FAIL b2b_wd1 got %h want %h", rf_wdata, D1); else pass_cnt++;
      tick();
      mem_wb_valid = 1'b0;
      #1;
      total_cnt++; if (alu_wb_ready !== 1'b1) $display("FAIL b2b_alu_rdy3 got %b want 1", alu_wb_ready); else pass_cnt++;
      total_cnt++; if (rf_we !== 1'b1) $display("FAIL b2b_we2 got %b want 1", rf_we); else pass_cnt++;
      total_cnt++; if (rf_rd !== 5'd2) $display("FAIL b2b_rd2 got %0d want 2", rf_rd); else pass_cnt++;
      total_cnt++; if (rf_wdata !== D2) $display("FAIL b2b_wd2 got %h want %h", rf_wdata, D2); else pass_cnt++;
      total_cnt++; if (busy !== 32'h0000_0004) $display("FAIL b2b_busy1 got %h want %h", busy, 32'h0000_0004); else pass_cnt++;
      tick();
      alu_wb_valid = 1'b0;
      total_cnt++; if (rf_rd !== 5'd1) $display("FAIL b2b_rd3 got %0d want 1", rf_rd); else pass_cnt++;
      total_cnt++; if (rf_wdata !== D3) $display("FAIL b2b_wd3 got %h want %h", rf_wdata, D3); else pass_cnt++;
      total_cnt++; if (wb_err !== 1'b1) $display("FAIL b2b_err got %b want 1", wb_err); else pass_cnt++;
      total_cnt++; if (busy !== 32'h0) $display("FAIL b2b_busy2 got %h want 0", busy); else pass_cnt++;
      tick();
      total_cnt++; if (rf_we !== 1'b0) $display("FAIL b2b_we_off got %b want 0", rf_we); else pass_cnt++;
      total_cnt++; if (wb_err !== 1'b0) $display("FAIL b2b_err_off got %b want 0", wb_err); else pass_cnt++;
   endtask

   task automatic test_spurious();
      mem_wb_valid = 1'b1; mem_wb_rd = 5'd9; mem_wb_data = D9;
      #1;
      total_cnt++; if (mem_wb_ready !== 1'b1) $display("FAIL sp_mem_rdy got %b want 1", mem_wb_ready); else pass_cnt++;
      tick();
      mem_wb_valid = 1'b0;
      total_cnt++; if (wb_err !== 1'b1) $display("FAIL sp_err got %b want 1", wb_err); else pass_cnt++;
      total_cnt++; if (rf_we !== 1'b1) $display("FAIL sp_we got %b want 1", rf_we); else pass_cnt++;
      total_cnt++; if (rf_rd !== 5'd9) $display("FAIL sp_rd got %0d want 9", rf_rd); else pass_cnt++;
      total_cnt++; if (rf_wdata !== D9) $display("FAIL sp_wd got %h want %h", rf_wdata, D9); else pass_cnt++;
      total_cnt++; if (busy[9] !== 1'b0) $display("FAIL sp_busy got %b want 0", busy[9]); else pass_cnt++;
      tick();
      total_cnt++; if (wb_err !== 1'b0) $display("FAIL sp_err_off got %b want 0", wb_err); else pass_cnt++;
      total_cnt++; if (busy !== 32'h0) $display("FAIL sp_busy2 got %h want 0", busy); else pass_cnt++;
   endtask

   task automatic test_reset_midop();
      alu_wb_valid = 1'b1; alu_wb_rd = 5'd10; alu_wb_data = D1;
      set_issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
      #1;
      total_cnt++; if (alu_wb_ready !== 1'b1) $display("FAIL rm_alu_rdy0 got %b want 1", alu_wb_ready); else pass_cnt++;
      tick();
      issue_valid = 1'b0;
      alu_wb_rd = 5'd4; alu_wb_data = D2;
      rst = 1'b1;
      #1;
      total_cnt++; if (busy !== 32'h0000_0010) $display("FAIL rm_busy0 got %h want %h", busy, 32'h0000_0010); else pass_cnt++;
      total_cnt++; if (wb_err !== 1'b1) $display("FAIL rm_err0 got %b want 1", wb_err); else pass_cnt++;
      tick();
      rst = 1'b0;
      alu_wb_valid = 1'b0;
      #1;
      total_cnt++; if (rf_we !== 1'b0) $display("FAIL rm_we got %b want 0", rf_we); else pass_cnt++;
      total_cnt++; if (busy !== 32'h0) $display("FAIL rm_busy got %h want 0", busy); else pass_cnt++;
      total_cnt++; if (wb_err !== 1'b0) $display("FAIL rm_err got %b want 0", wb_err); else pass_cnt++;
      alu_wb_valid = 1'b1; alu_wb_rd = 5'd11;
      mem_wb_valid = 1'b1; mem_wb_rd = 5'd12;
      #1;
      total_cnt++; if (alu_wb_ready !== 1'b1) $display("FAIL rm_alu_rdy got %b want 1", alu_wb_ready); else pass_cnt++;
      total_cnt++; if (mem_wb_ready !== 1'b0) $display("FAIL rm_mem_rdy got %b want 0", mem_wb_ready); else pass_cnt++;
      alu_wb_valid = 1'b0;
      mem_wb_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_issue();
      test_raw();
      test_waw();
      test_back_to_back();
      test_spurious();
      test_reset_midop();
      tick();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
